// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants for the writeback/register-file slice.
package mips_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Writeback source indices on the register-file write arbiter
   localparam int unsigned WB_SRC_ALU    = 0;
   localparam int unsigned WB_SRC_LOAD   = 1;
   localparam int unsigned WB_SRC_MULDIV = 2;

   // Width of requester indices (covers up to 8 requesters)
   localparam int unsigned IDX_W = 3;

   // Round-robin successor of index g among n requesters
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g,
                                                input int unsigned     n);
      logic [IDX_W-1:0] nxt;
      if (32'(g) >= n - 1) nxt = '0;
      else                 nxt = g + 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo N, gets a one-hot grant plus its encoded index.
module rr_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   int unsigned k;
   logic        found;

   // Scan from the pointer upward with wrap-around, first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (32'(ptr) + i) % N;
         if (!found && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = IDX_W'(k);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources: round-robin grant, one registered write per clock.
module regfile_write_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = REG_ADDR_W,
   parameter int unsigned DATA_W  = REG_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      hold,
   output logic                      RegWrite,
   output logic [ADDR_W-1:0]         WriteRegister,
   output logic [DATA_W-1:0]         WriteData,
   output logic [2:0]                grant_id
);

   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               accept;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Grant is suppressed while held or in reset; acceptance is any grant
   always_comb begin
      req_ready = (reset || hold) ? '0 : gnt;
      accept    = |req_ready;
   end

   // Select the granted requester's address and data slices
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output register and round-robin pointer; writes to $zero are dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr           <= '0;
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
         grant_id      <= '0;
      end else begin
         RegWrite <= accept && (sel_addr != ADDR_W'(REG_ZERO));
         if (accept) begin
            WriteRegister <= sel_addr;
            WriteData     <= sel_data;
            grant_id      <= gnt_idx;
            ptr           <= rr_next(gnt_idx, NUM_REQ);
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench for regfile_write_arbiter (NUM_REQ=3).
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        hold;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic [2:0]  grant_id;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  ready;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [2:0]  gid;
   } exp_t;

   exp_t exp_q[$];

   regfile_write_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .hold          (hold),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every cycle that has a pending expectation
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("req_ready",     64'(req_ready),     64'(e.ready));
         check("RegWrite",      64'(RegWrite),      64'(e.we));
         check("WriteRegister", 64'(WriteRegister), 64'(e.addr));
         check("WriteData",     64'(WriteData),     64'(e.data));
         check("grant_id",      64'(grant_id),      64'(e.gid));
      end
   end

   // One cycle: drive inputs, queue expected ready for this cycle and the
   // port state produced by the previous edge
   task automatic step(input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic h, input logic [2:0] er,
                       input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                       input logic [2:0] eg);
      exp_t e;
      @(posedge clk);
      #1;
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
      hold      = h;
      e.ready = er; e.we = ewe; e.addr = ea; e.data = ed; e.gid = eg;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = '0;
      hold      = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      hold      = 1'b0;
      #2;
      check("reset_ready",    64'(req_ready),     64'h0);
      check("reset_regwrite", 64'(RegWrite),      64'h0);
      check("reset_wreg",     64'(WriteRegister), 64'h0);
      check("reset_wdata",    64'(WriteData),     64'h0);
      check("reset_gid",      64'(grant_id),      64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single write from requester 0
      step(3'b001, 5, 0, 0, 32'h12345678, 0, 0, 0, 3'b001, 0, 0, 0, 0);
      step(3'b000, 5, 0, 0, 32'h12345678, 0, 0, 0, 3'b000, 1, 5, 32'h12345678, 0);
      step(3'b000, 5, 0, 0, 32'h12345678, 0, 0, 0, 3'b000, 0, 5, 32'h12345678, 0);

      do_reset();

      // All three valid continuously from pointer 0
      step(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b001, 0, 0, 0, 0);
      step(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b010, 1, 1, 32'hA1, 0);
      step(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b100, 1, 2, 32'hA2, 1);
      step(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b001, 1, 3, 32'hA3, 2);
      step(3'b000, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b000, 1, 1, 32'hA1, 0);
      step(3'b000, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b000, 0, 1, 32'hA1, 0);

      // Write to $zero is accepted but dropped; req2 follows (pointer 1)
      step(3'b110, 0, 0, 7, 0, 32'hFFFFFFFF, 32'h77, 0, 3'b010, 0, 1, 32'hA1, 0);
      step(3'b100, 0, 0, 7, 0, 32'hFFFFFFFF, 32'h77, 0, 3'b100, 0, 0, 32'hFFFFFFFF, 1);
      step(3'b000, 0, 0, 7, 0, 32'hFFFFFFFF, 32'h77, 0, 3'b000, 1, 7, 32'h77, 2);
      step(3'b001, 10, 0, 0, 32'h55, 0, 0, 0, 3'b001, 0, 7, 32'h77, 2);

      // Same destination from req0 and req2 with pointer 1
      step(3'b101, 9, 0, 9, 32'hA, 0, 32'hB, 0, 3'b100, 1, 10, 32'h55, 0);
      step(3'b001, 9, 0, 9, 32'hA, 0, 32'hB, 0, 3'b001, 1, 9, 32'hB, 2);
      step(3'b000, 9, 0, 9, 32'hA, 0, 32'hB, 0, 3'b000, 1, 9, 32'hA, 0);

      // Hold blocks grants for four cycles
      for (int c = 0; c < 4; c++)
         step(3'b010, 0, 12, 0, 0, 32'hC0DE, 0, 1, 3'b000, 0, 9, 32'hA, 0);
      step(3'b010, 0, 12, 0, 0, 32'hC0DE, 0, 0, 3'b010, 0, 9, 32'hA, 0);
      step(3'b000, 0, 12, 0, 0, 32'hC0DE, 0, 0, 3'b000, 1, 12, 32'hC0DE, 1);

      // Reset during an active write, pointer left at 1 beforehand
      step(3'b001, 4, 0, 0, 32'h44, 0, 0, 0, 3'b001, 0, 12, 32'hC0DE, 1);
      @(posedge clk);
      #1;
      req_valid = '0;
      check("pre_reset_regwrite", 64'(RegWrite),      64'h1);
      check("pre_reset_wreg",     64'(WriteRegister), 64'h4);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset_regwrite", 64'(RegWrite),  64'h0);
      check("async_reset_ready",    64'(req_ready), 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(3'b011, 20, 21, 0, 32'h200, 32'h210, 0, 0, 3'b001, 0, 0, 0, 0);
      step(3'b010, 20, 21, 0, 32'h200, 32'h210, 0, 0, 3'b010, 1, 20, 32'h200, 0);
      step(3'b000, 20, 21, 0, 32'h200, 32'h210, 0, 0, 3'b000, 1, 21, 32'h210, 1);
      step(3'b000, 20, 21, 0, 32'h200, 32'h210, 0, 0, 3'b000, 0, 21, 32'h210, 1);

      // Drain the scoreboard with a bounded wait
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
      @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
